bsg_axil_csr_slave: RTL and testbench

AXI4-Lite slave that terminates the host-side AXI-Lite master port and exposes a bank of word-wide control/status registers to the PL design. Sits directly downstream of the DPI/PS AXI-Lite master and consumes its AW/W/B/AR/R channels. It decodes word addresses into writable control registers and read-only status inputs. It returns OKAY or SLVERR, with one outstanding transaction per direction.

---
 rtl/bsg_axil_pkg.sv | 15 +
 rtl/bsg_axil_csr_decode.sv | 38 +++
 rtl/bsg_axil_csr_slave.sv | 174 +++++++++++++++++
 tb/tb_bsg_axil_csr_slave.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_axil_pkg.sv
// Shared AXI4-Lite definitions for the CSR slave: response encodings and
// the width of a decoded register index.
package bsg_axil_pkg;

  typedef enum logic [1:0] {
    e_axil_resp_okay   = 2'b00,
    e_axil_resp_slverr = 2'b10
  } axil_resp_e;

  // Bits needed to index num_words registers; never narrower than one bit.
  function automatic int idx_width(input int num_words);
    return (num_words <= 2) ? 1 : $clog2(num_words);
  endfunction

endpackage

// File: rtl/bsg_axil_csr_decode.sv
// Combinational address decode for the CSR bank: classifies a byte address
// as control register, status word or unmapped, and yields its word index.
module bsg_axil_csr_decode
  import bsg_axil_pkg::*;
#(
  parameter int                      addr_width_p = 32,
  parameter int                      data_width_p = 32,
  parameter logic [addr_width_p-1:0] base_addr_p  = '0,
  parameter int                      num_regs_p   = 4,
  parameter int                      num_status_p = 2,
  localparam int                     idx_width_lp = idx_width(num_regs_p + num_status_p)
) (
  input  logic [addr_width_p-1:0] addr,
  output logic                    is_ctrl,
  output logic                    is_status,
  output logic [idx_width_lp-1:0] idx
);

  localparam int                      lg_bytes_lp = $clog2(data_width_p / 8);
  localparam logic [addr_width_p-1:0] nregs_lp    = addr_width_p'(num_regs_p);
  localparam logic [addr_width_p-1:0] nmapped_lp  = addr_width_p'(num_regs_p + num_status_p);

  logic [addr_width_p-1:0] offset;
  logic [addr_width_p-1:0] word;
  logic                    above_base;

  // The full-width word index feeds the range checks, so large offsets that
  // would alias after truncation still land in the unmapped region.
  always_comb begin
    offset     = addr - base_addr_p;
    word       = offset >> lg_bytes_lp;
    above_base = (addr >= base_addr_p);
    is_ctrl    = above_base && (word < nregs_lp);
    is_status  = above_base && (word >= nregs_lp) && (word < nmapped_lp);
    idx        = word[idx_width_lp-1:0];
  end

endmodule

// File: rtl/bsg_axil_csr_slave.sv
// AXI4-Lite slave exposing a bank of control registers and read-only status
// words. Define BSG_AXIL_CSR_WSTRB_EN to honour wstrb byte lanes on writes.
module bsg_axil_csr_slave
  import bsg_axil_pkg::*;
#(
  parameter int                      addr_width_p    = 32,
  parameter int                      data_width_p    = 32,
  parameter logic [addr_width_p-1:0] base_addr_p     = '0,
  parameter int                      num_regs_p      = 4,
  parameter int                      num_status_p    = 2,
  localparam int                     strb_width_lp   = data_width_p / 8,
  localparam int                     status_words_lp = (num_status_p > 0) ? num_status_p : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [addr_width_p-1:0]               awaddr_i,
  input  logic [2:0]                            awprot_i,
  input  logic                                  awvalid_i,
  output logic                                  awready_o,
  input  logic [data_width_p-1:0]               wdata_i,
  input  logic [strb_width_lp-1:0]              wstrb_i,
  input  logic                                  wvalid_i,
  output logic                                  wready_o,
  output logic [1:0]                            bresp_o,
  output logic                                  bvalid_o,
  input  logic                                  bready_i,
  input  logic [addr_width_p-1:0]               araddr_i,
  input  logic [2:0]                            arprot_i,
  input  logic                                  arvalid_i,
  output logic                                  arready_o,
  output logic [data_width_p-1:0]               rdata_o,
  output logic [1:0]                            rresp_o,
  output logic                                  rvalid_o,
  input  logic                                  rready_i,
  output logic [num_regs_p*data_width_p-1:0]    csr_o,
  output logic [num_regs_p-1:0]                 csr_we_o,
  input  logic [status_words_lp*data_width_p-1:0] status_i
);

  localparam int idx_width_lp = idx_width(num_regs_p + num_status_p);

  logic                    aw_v_reg, w_v_reg, bvalid_reg, rvalid_reg;
  logic [addr_width_p-1:0] awaddr_reg;
  logic [data_width_p-1:0] wdata_reg, rdata_reg, rdata_next;
  logic [1:0]              bresp_reg, rresp_reg, rresp_next;
  logic [num_regs_p-1:0]   we_hit, csr_we_reg;
  logic [data_width_p-1:0] csr_reg     [num_regs_p];
  logic [data_width_p-1:0] wr_word     [num_regs_p];
  logic [data_width_p-1:0] status_word [status_words_lp];
  logic                    w_is_ctrl, r_is_ctrl, r_is_status, unused_w_is_status;
  logic [idx_width_lp-1:0] w_idx, r_idx;
  logic                    commit, ar_hs, unused_inputs;
`ifdef BSG_AXIL_CSR_WSTRB_EN
  logic [strb_width_lp-1:0] wstrb_reg;
`endif

  bsg_axil_csr_decode #(
    .addr_width_p(addr_width_p), .data_width_p(data_width_p), .base_addr_p(base_addr_p),
    .num_regs_p(num_regs_p), .num_status_p(num_status_p)
  ) wr_decode (
    .addr(awaddr_reg), .is_ctrl(w_is_ctrl), .is_status(unused_w_is_status), .idx(w_idx)
  );

  bsg_axil_csr_decode #(
    .addr_width_p(addr_width_p), .data_width_p(data_width_p), .base_addr_p(base_addr_p),
    .num_regs_p(num_regs_p), .num_status_p(num_status_p)
  ) rd_decode (
    .addr(araddr_i), .is_ctrl(r_is_ctrl), .is_status(r_is_status), .idx(r_idx)
  );

  assign commit    = aw_v_reg & w_v_reg & ~bvalid_reg;
  assign ar_hs     = arvalid_i & ~rvalid_reg;
  assign awready_o = ~aw_v_reg;
  assign wready_o  = ~w_v_reg;
  assign arready_o = ~rvalid_reg;
  assign bvalid_o  = bvalid_reg;
  assign bresp_o   = bresp_reg;
  assign rvalid_o  = rvalid_reg;
  assign rdata_o   = rdata_reg;
  assign rresp_o   = rresp_reg;
  assign csr_we_o  = csr_we_reg;

`ifdef BSG_AXIL_CSR_WSTRB_EN
  assign unused_inputs = ^{awprot_i, arprot_i};
`else
  assign unused_inputs = ^{awprot_i, arprot_i, wstrb_i};
`endif

  genvar gi;
  for (gi = 0; gi < num_regs_p; gi++) begin : g_reg
    assign we_hit[gi] = commit & w_is_ctrl & (w_idx == idx_width_lp'(gi));
    assign csr_o[gi*data_width_p +: data_width_p] = csr_reg[gi];
  end

  for (gi = 0; gi < status_words_lp; gi++) begin : g_status
    assign status_word[gi] = status_i[gi*data_width_p +: data_width_p];
  end

  always_comb begin
    for (int k = 0; k < num_regs_p; k++) begin
      wr_word[k] = wdata_reg;
`ifdef BSG_AXIL_CSR_WSTRB_EN
      for (int b = 0; b < strb_width_lp; b++)
        if (!wstrb_reg[b]) wr_word[k][8*b +: 8] = csr_reg[k][8*b +: 8];
`endif
    end
  end

  // Control reads see the pre-commit register value on a same-edge write.
  always_comb begin
    rdata_next = '0;
    rresp_next = e_axil_resp_slverr;
    if (r_is_ctrl) begin
      rresp_next = e_axil_resp_okay;
      for (int k = 0; k < num_regs_p; k++)
        if (r_idx == idx_width_lp'(k)) rdata_next = csr_reg[k];
    end else if (r_is_status) begin
      rresp_next = e_axil_resp_okay;
      for (int k = 0; k < num_status_p; k++)
        if (r_idx == idx_width_lp'(num_regs_p + k)) rdata_next = status_word[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      aw_v_reg   <= 1'b0;
      w_v_reg    <= 1'b0;
      bvalid_reg <= 1'b0;
      rvalid_reg <= 1'b0;
      awaddr_reg <= '0;
      wdata_reg  <= '0;
      bresp_reg  <= '0;
      rdata_reg  <= '0;
      rresp_reg  <= '0;
      csr_we_reg <= '0;
`ifdef BSG_AXIL_CSR_WSTRB_EN
      wstrb_reg  <= '0;
`endif
      for (int k = 0; k < num_regs_p; k++) csr_reg[k] <= '0;
    end else begin
      csr_we_reg <= we_hit;
      if (awvalid_i && !aw_v_reg) begin
        aw_v_reg   <= 1'b1;
        awaddr_reg <= awaddr_i;
      end
      if (wvalid_i && !w_v_reg) begin
        w_v_reg   <= 1'b1;
        wdata_reg <= wdata_i;
`ifdef BSG_AXIL_CSR_WSTRB_EN
        wstrb_reg <= wstrb_i;
`endif
      end
      // Capture and commit are mutually exclusive: capture needs an empty slot.
      if (commit) begin
        aw_v_reg   <= 1'b0;
        w_v_reg    <= 1'b0;
        bvalid_reg <= 1'b1;
        bresp_reg  <= w_is_ctrl ? e_axil_resp_okay : e_axil_resp_slverr;
      end else if (bvalid_reg && bready_i) begin
        bvalid_reg <= 1'b0;
      end
      for (int k = 0; k < num_regs_p; k++)
        if (we_hit[k]) csr_reg[k] <= wr_word[k];
      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rdata_next;
        rresp_reg  <= rresp_next;
      end else if (rvalid_reg && rready_i) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bsg_axil_csr_slave.sv
// Directed bench for bsg_axil_csr_slave: a vector table of single AXI-Lite
// transactions plus hand-written sequences for stalls, same-edge hazards and reset.
module tb_bsg_axil_csr_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;
  logic [127:0] csr_o;
  logic [3:0]   csr_we_o;
  logic [63:0]  status_i;

  bsg_axil_csr_slave #(
    .addr_width_p(32), .data_width_p(32), .base_addr_p(BASE),
    .num_regs_p(4), .num_status_p(2)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .awaddr_i(awaddr), .awprot_i(awprot), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arprot_i(arprot), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .csr_o(csr_o), .csr_we_o(csr_we_o), .status_i(status_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs [12];
  int          n_cmp = 0;
  int          n_err = 0;
  int          we_cnt [4] = '{default: 0};
  int          lat, base_cnt;
  logic [1:0]  resp;
  logic [31:0] rd, exp_strb;

  always @(negedge clk)
    for (int k = 0; k < 4; k++)
      if (csr_we_o[k]) we_cnt[k]++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r, output int l);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    l = 0;
    while (!(awready && wready) && l < 20) begin @(negedge clk); l++; end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    l = 1;
    while (!bvalid && l < 20) begin @(negedge clk); l++; end
    r = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int l);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    l = 0;
    while (!arready && l < 20) begin @(negedge clk); l++; end
    @(negedge clk);
    arvalid = 1'b0;
    l = 1;
    while (!rvalid && l < 20) begin @(negedge clk); l++; end
    d = rdata; r = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, BASE + 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, BASE + 32'h04, 32'h0,        4'hF, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, BASE + 32'h10, 32'h0,        4'hF, 2'b00, 32'h12345678};
    vecs[3]  = '{1'b0, BASE + 32'h14, 32'h0,        4'hF, 2'b00, 32'h9ABCDEF0};
    vecs[4]  = '{1'b0, BASE + 32'h100, 32'h0,       4'hF, 2'b10, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0FFC, 32'h0,        4'hF, 2'b10, 32'h0};
    vecs[6]  = '{1'b1, BASE + 32'h10, 32'h00000055, 4'hF, 2'b10, 32'h0};
    vecs[7]  = '{1'b0, BASE + 32'h00, 32'h0,        4'hF, 2'b00, 32'h0};
    vecs[8]  = '{1'b1, BASE + 32'h0C, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, BASE + 32'h0E, 32'h0,        4'hF, 2'b00, 32'hCAFEF00D};
    vecs[10] = '{1'b1, BASE + 32'h18, 32'h77777777, 4'hF, 2'b10, 32'h0};
    vecs[11] = '{1'b0, BASE + 32'h18, 32'h0,        4'hF, 2'b10, 32'h0};

    reset = 1'b1;
    awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    status_i = {32'h9ABCDEF0, 32'h12345678};
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset readies", {awready, wready, arready}, 3'b111);
    check("reset valids", {bvalid, rvalid}, 2'b00);
    check("reset resps", {bresp, rresp}, 4'b0000);
    check("reset rdata", rdata, 32'h0);
    check("reset csr_lo", csr_o[63:0], 64'h0);
    check("reset csr_hi", csr_o[127:64], 64'h0);
    check("reset csr_we", csr_we_o, 4'h0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
        check($sformatf("vec%0d wr bresp", i), resp, vecs[i].resp);
        check($sformatf("vec%0d wr latency", i), lat, 2);
      end else begin
        axi_read(vecs[i].addr, rd, resp, lat);
        check($sformatf("vec%0d rd rresp", i), resp, vecs[i].resp);
        check($sformatf("vec%0d rd rdata", i), rd, vecs[i].rdata);
        check($sformatf("vec%0d rd latency", i), lat, 1);
      end
    end

    check("table csr reg0", csr_o[31:0], 32'h0);
    check("table csr reg1", csr_o[63:32], 32'hDEADBEEF);
    check("table csr reg2", csr_o[95:64], 32'h0);
    check("table csr reg3", csr_o[127:96], 32'hCAFEF00D);
    check("table we pulses", {we_cnt[3][3:0], we_cnt[2][3:0], we_cnt[1][3:0], we_cnt[0][3:0]},
          16'h1010);

    // W early, AW three cycles later, B stalled while a second write queues.
    base_cnt = we_cnt[0];
    @(negedge clk);
    awaddr = BASE; wdata = 32'h11112222; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("seqA wready held", wready, 1'b0);
    check("seqA awready idle", awready, 1'b1);
    repeat (2) @(negedge clk);
    check("seqA no commit w/o aw", bvalid, 1'b0);
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("seqA awready held", awready, 1'b0);
    check("seqA bvalid not yet", bvalid, 1'b0);
    @(negedge clk);
    check("seqA bvalid", bvalid, 1'b1);
    check("seqA bresp", bresp, 2'b00);
    check("seqA reg0 first", csr_o[31:0], 32'h11112222);
    awaddr = BASE; wdata = 32'h33334444; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("seqA queued readies", {awready, wready}, 2'b00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("seqA stall%0d bvalid", c), bvalid, 1'b1);
      check($sformatf("seqA stall%0d reg0", c), csr_o[31:0], 32'h11112222);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("seqA b cleared", bvalid, 1'b0);
    @(negedge clk);
    check("seqA second bvalid", bvalid, 1'b1);
    check("seqA reg0 second", csr_o[31:0], 32'h33334444);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("seqA we pulses", we_cnt[0] - base_cnt, 2);

    // Same-edge commit and read of reg2 returns the old value.
    axi_write(BASE + 32'h8, 32'h0000000A, 4'hF, resp, lat);
    @(negedge clk);
    awaddr = BASE + 32'h8; wdata = 32'h0000000B; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = BASE + 32'h8; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("seqB rvalid", rvalid, 1'b1);
    check("seqB rdata old", rdata, 32'hA);
    check("seqB bvalid", bvalid, 1'b1);
    check("seqB reg2 new", csr_o[95:64], 32'hB);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    axi_read(BASE + 32'h8, rd, resp, lat);
    check("seqB reread", rd, 32'hB);

    // Byte-lane strobes.
`ifdef BSG_AXIL_CSR_WSTRB_EN
    exp_strb = 32'hFF00FF00;
`else
    exp_strb = 32'h00000000;
`endif
    axi_write(BASE, 32'hFFFFFFFF, 4'hF, resp, lat);
    axi_write(BASE, 32'h00000000, 4'b0101, resp, lat);
    check("seqC strb bresp", resp, 2'b00);
    axi_read(BASE, rd, resp, lat);
    check("seqC strb reg0", rd, exp_strb);

    // Reset drops a held W and a pending R.
    @(negedge clk);
    awaddr = BASE + 32'h4; wdata = 32'h5A5A5A5A; wvalid = 1'b1;
    araddr = BASE + 32'h4; arvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; arvalid = 1'b0;
    check("seqD w held", wready, 1'b0);
    check("seqD r pending", rvalid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("seqD readies after reset", {awready, wready, arready}, 3'b111);
    check("seqD valids after reset", {bvalid, rvalid}, 2'b00);
    check("seqD csr cleared", csr_o[63:0], 64'h0);
    axi_write(BASE + 32'h4, 32'h0BADF00D, 4'hF, resp, lat);
    check("seqD post-reset write lat", lat, 2);
    check("seqD post-reset reg1", csr_o[63:32], 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
